// File: rtl/msg_scroller.sv
// msg_scroller: loadable message buffer scrolled left through an 8-character window with a trailing blank gap
module msg_scroller #(
  parameter int CHAR_W = 5,
  parameter int WIN_CHARS = 8,
  parameter int MAX_LEN = 32,
  parameter int GAP = 2,
  parameter logic [CHAR_W-1:0] BLANK = 5'h1F,
  parameter int ADDR_W = $clog2(MAX_LEN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        step,
  input  logic                        run,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [CHAR_W-1:0]           wr_char,
  input  logic [ADDR_W:0]             msg_len,
  output logic [CHAR_W*WIN_CHARS-1:0] window,
  output logic [ADDR_W:0]             pos,
  output logic                        wrap
);
  logic [CHAR_W-1:0] mem [MAX_LEN];
  logic [ADDR_W:0] len_c, pos_nx;
  logic [ADDR_W+1:0] last;
  logic [CHAR_W-1:0] next_char;
  logic shift;
  always_comb begin
    len_c = (msg_len > (ADDR_W+1)'(MAX_LEN)) ? (ADDR_W+1)'(MAX_LEN) : msg_len;
    last = (ADDR_W+2)'(len_c) + (ADDR_W+2)'(GAP - 1);
    next_char = (pos < len_c) ? mem[pos[ADDR_W-1:0]] : BLANK;
    shift = run & step;
    pos_nx = ((ADDR_W+2)'(pos) >= last) ? '0 : pos + (ADDR_W+1)'(1);
  end
  // RAM is never cleared; reset only drops a concurrent write
  always_ff @(posedge clk)
    if (!rst && wr_en && 32'(wr_addr) < MAX_LEN) mem[wr_addr] <= wr_char;
  always_ff @(posedge clk)
    if (rst) begin
      window <= {WIN_CHARS{BLANK}};
      pos <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= shift && pos_nx == '0;
      if (shift) begin
        window <= {window[CHAR_W*WIN_CHARS-CHAR_W-1:0], next_char};
        pos <= pos_nx;
      end
    end
endmodule
